// File: rtl/six_to_one_arb.sv
// ---------------------------------------------------------------------------
// six_to_one_arb
//
// Purpose:
//   Round-robin arbiter and two-stage pipeline sequencer. It shares a single
//   combinational six_to_one_rtl datapath among NREQ requesters. The granted
//   operand pair is registered onto dp_a/dp_b (stage S1). One cycle later the
//   datapath result dp_x is captured into the response register (stage S2).
//   It is then returned with the owning requester ID over a backpressured
//   response channel.
//
// Ports:
//   clk        in   1        single clock, all state on posedge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester request valid
//   req_a      in   5*NREQ   operand A, requester i at [5i+4:5i]
//   req_b      in   2*NREQ   operand B, requester i at [2i+1:2i]
//   req_ready  out  NREQ     one-hot combinational accept, 0 during reset
//   dp_a       out  5        registered A driven to the datapath
//   dp_b       out  2        registered B driven to the datapath
//   dp_x       in   8        datapath result, combinational from dp_a/dp_b
//   rsp_valid  out  1        response valid
//   rsp_ready  in   1        response consumer ready
//   rsp_x      out  8        captured datapath result
//   rsp_id     out  IDW      requester that owns rsp_x
//   busy       out  1        either pipeline stage occupied
//   rsp_count  out  16       completed response handshakes, wrapping
// ---------------------------------------------------------------------------
module six_to_one_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_a,
  input  logic [2*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [4:0]           dp_a,
  output logic [1:0]           dp_b,
  input  logic [7:0]           dp_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_x,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          rsp_count
);

  // Stage S1 (issue) state: operands currently presented to the datapath.
  logic           r_s1Valid;
  logic [IDW-1:0] r_s1Id;
  logic [4:0]     r_dpA;
  logic [1:0]     r_dpB;

  // Stage S2 (output) state: the captured response.
  logic           r_s2Valid;
  logic [IDW-1:0] r_rspId;
  logic [7:0]     r_rspX;

  // Round-robin pointer and completed-response counter.
  logic [IDW-1:0] r_ptr;
  logic [15:0]    r_rspCount;

  // Pipeline control and arbitration results.
  logic           w_s2Free;
  logic           w_s1Load;
  logic           w_s1ToS2;
  logic           w_rspFire;
  logic           w_anyReq;
  logic [IDW-1:0] w_grant;
  logic           w_accept;
  logic [4:0]     w_selA;
  logic [1:0]     w_selB;

  // Adds an offset to a requester index modulo NREQ. Both operands are
  // always below NREQ, so a single conditional subtract is enough; this also
  // keeps the wrap correct when NREQ is not a power of two.
  function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base,
                                             input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return sum[IDW-1:0];
  endfunction

  // Pipeline advance conditions. S2 can take new data when it is empty or
  // being drained this cycle. S1 can load when it is empty or its contents
  // are moving into S2 on the same edge. This lets drain, transfer and a new
  // accept all happen together, giving one response per cycle.
  assign w_s2Free  = !r_s2Valid || rsp_ready;
  assign w_s1ToS2  = r_s1Valid && w_s2Free;
  assign w_s1Load  = !r_s1Valid || w_s2Free;
  assign w_rspFire = r_s2Valid && rsp_ready;

  // Rotating priority search. Start at the pointer, walk upward modulo
  // NREQ, and take the first requester with valid set. The pointer only
  // moves past a requester after it is accepted. So a lone requester
  // that stays valid wins every cycle.
  always_comb begin
    w_anyReq = 1'b0;
    w_grant  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_anyReq && req_valid[wrapAdd(r_ptr, k)]) begin
        w_anyReq = 1'b1;
        w_grant  = wrapAdd(r_ptr, k);
      end
    end
  end

  assign w_accept = w_anyReq && w_s1Load;

  // Pick the granted requester's operand slice for loading into S1.
  always_comb begin
    w_selA = req_a[5*int'(w_grant) +: 5];
    w_selB = req_b[2*int'(w_grant) +: 2];
  end

  // The ready vector is one-hot on the winner, and only when S1 can load.
  // It is gated by rst_n so that no requester sees an accept while the
  // pipeline is being held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Issue stage. On an accept, latch the winner's operands and ID and
  // advance the pointer past the winner. If S1 frees up with nothing to
  // accept, it goes empty. The operand registers keep their old values
  // so the datapath inputs do not toggle needlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Id    <= '0;
      r_dpA     <= '0;
      r_dpB     <= '0;
      r_ptr     <= '0;
    end else if (w_s1Load) begin
      if (w_accept) begin
        r_s1Valid <= 1'b1;
        r_s1Id    <= w_grant;
        r_dpA     <= w_selA;
        r_dpB     <= w_selB;
        r_ptr     <= wrapAdd(w_grant, 1);
      end else begin
        r_s1Valid <= 1'b0;
      end
    end
  end

  // Output stage. The combinational datapath result for the S1 operands is
  // captured as S1 moves forward. When S2 drains with nothing arriving, it
  // goes empty but the last result and ID stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_rspId   <= '0;
      r_rspX    <= '0;
    end else if (w_s2Free) begin
      if (w_s1ToS2) begin
        r_s2Valid <= 1'b1;
        r_rspId   <= r_s1Id;
        r_rspX    <= dp_x;
      end else begin
        r_s2Valid <= 1'b0;
      end
    end
  end

  // Count every completed response handshake; the 16-bit counter simply
  // wraps from all-ones back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspCount <= '0;
    end else if (w_rspFire) begin
      r_rspCount <= r_rspCount + 16'd1;
    end
  end

  assign dp_a      = r_dpA;
  assign dp_b      = r_dpB;
  assign rsp_valid = r_s2Valid;
  assign rsp_x     = r_rspX;
  assign rsp_id    = r_rspId;
  assign busy      = r_s1Valid || r_s2Valid;
  assign rsp_count = r_rspCount;

endmodule
